// File: rtl/uart_rx_fifo.sv
// Receive-side FWFT byte FIFO with sticky error/status flags for the UART receiver.
// Optional level-threshold interrupt enabled by defining UART_RX_FIFO_THRESH_EN.
module uart_rx_fifo #(
   parameter int Depth       = 16,
   parameter int DataWidth   = 8,
   parameter int ThreshLevel = 8
) (
   input  logic                   clk_i,
   input  logic                   reset_n_i,
   input  logic [DataWidth-1:0]   rx_data_i,
   input  logic                   rx_valid_i,
   input  logic                   rx_frame_error_i,
   input  logic                   rx_parity_error_i,
   input  logic                   rd_en_i,
   input  logic                   flush_i,
   input  logic                   clr_status_i,
   output logic [DataWidth-1:0]   rd_data_o,
   output logic                   empty_o,
   output logic                   full_o,
   output logic [$clog2(Depth):0] count_o,
   output logic                   overrun_o,
   output logic                   underflow_o,
   output logic                   frame_err_o,
   output logic                   parity_err_o,
   output logic                   irq_o
);

   localparam int AW = $clog2(Depth);
   localparam int CW = AW + 1;

   generate
      if (Depth < 2 || (Depth & (Depth - 1)) != 0 || ThreshLevel < 1 || ThreshLevel > Depth)
      begin : g_param_check
         $error("uart_rx_fifo: illegal Depth/ThreshLevel combination");
      end
   endgenerate

   logic [DataWidth-1:0] mem [Depth];
   logic [AW-1:0]        rd_ptr_reg, wr_ptr_reg;
   logic [CW-1:0]        count_reg, count_next;
   logic                 empty_reg, full_reg;
   logic                 is_empty, is_full;
   logic                 pop_ok, wr_ok;
   logic [3:0]           flag_set, flag_reg;

   assign is_empty = (count_reg == '0);
   assign is_full  = (count_reg == CW'(Depth));

   // A pop frees the slot, so a write into a full FIFO is accepted when a pop accompanies it.
   assign pop_ok = rd_en_i & ~is_empty & ~flush_i;
   assign wr_ok  = rx_valid_i & ~flush_i & (~is_full | pop_ok);

   always_comb begin
      count_next = count_reg;
      if (flush_i) begin
         count_next = '0;
      end else begin
         case ({wr_ok, pop_ok})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         rd_ptr_reg <= '0;
         wr_ptr_reg <= '0;
         count_reg  <= '0;
         empty_reg  <= 1'b1;
         full_reg   <= 1'b0;
      end else begin
         count_reg <= count_next;
         empty_reg <= (count_next == '0);
         full_reg  <= (count_next == CW'(Depth));
         if (flush_i) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
         end else begin
            if (pop_ok) rd_ptr_reg <= rd_ptr_reg + AW'(1);
            if (wr_ok)  wr_ptr_reg <= wr_ptr_reg + AW'(1);
         end
      end
   end

   // Storage is left unreset so it maps onto distributed/block RAM.
   always_ff @(posedge clk_i) begin
      if (wr_ok) mem[wr_ptr_reg] <= rx_data_i;
   end

   assign rd_data_o = mem[rd_ptr_reg];

   // Flag order: {overrun, underflow, frame error, parity error}.
   assign flag_set[3] = rx_valid_i & ~flush_i & ~wr_ok;
   assign flag_set[2] = rd_en_i & is_empty & ~flush_i;
   assign flag_set[1] = rx_frame_error_i;
   assign flag_set[0] = rx_parity_error_i;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         flag_reg <= '0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (flag_set[i])       flag_reg[i] <= 1'b1;
            else if (clr_status_i) flag_reg[i] <= 1'b0;
         end
      end
   end

   assign overrun_o    = flag_reg[3];
   assign underflow_o  = flag_reg[2];
   assign frame_err_o  = flag_reg[1];
   assign parity_err_o = flag_reg[0];
   assign empty_o      = empty_reg;
   assign full_o       = full_reg;
   assign count_o      = count_reg;

`ifdef UART_RX_FIFO_THRESH_EN
   logic irq_reg;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) irq_reg <= 1'b0;
      else            irq_reg <= (count_next >= CW'(ThreshLevel));
   end

   assign irq_o = irq_reg;
`else
   assign irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_uart_rx_fifo;

   localparam int DEPTH  = 16;
   localparam int THRESH = 8;

   logic       clk = 1'b0;
   logic       reset_n = 1'b1;
   logic [7:0] rx_data = '0;
   logic       rx_valid = 1'b0, rx_fe = 1'b0, rx_pe = 1'b0;
   logic       rd_en = 1'b0, flush = 1'b0, clr = 1'b0;
   logic [7:0] rd_data;
   logic       empty, full, overrun, underflow, frame_err, parity_err, irq;
   logic [4:0] count;

   int errors = 0;
   int checks = 0;

   logic [7:0] mq[$];
   logic       m_ovr = 1'b0, m_und = 1'b0, m_fe = 1'b0, m_pe = 1'b0;

   always #5 clk = ~clk;

   uart_rx_fifo #(.Depth(DEPTH), .DataWidth(8), .ThreshLevel(THRESH)) dut (
      .clk_i(clk), .reset_n_i(reset_n), .rx_data_i(rx_data), .rx_valid_i(rx_valid),
      .rx_frame_error_i(rx_fe), .rx_parity_error_i(rx_pe), .rd_en_i(rd_en),
      .flush_i(flush), .clr_status_i(clr), .rd_data_o(rd_data), .empty_o(empty),
      .full_o(full), .count_o(count), .overrun_o(overrun), .underflow_o(underflow),
      .frame_err_o(frame_err), .parity_err_o(parity_err), .irq_o(irq)
   );

   function automatic logic exp_irq();
`ifdef UART_RX_FIFO_THRESH_EN
      return (mq.size() >= THRESH);
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [3:0] exp_flags();
      return {m_ovr, m_und, m_fe, m_pe};
   endfunction

   // One clock of stimulus; the model applies the transaction at the edge.
   task automatic step(input logic v, input logic [7:0] d, input logic rd,
                       input logic fl, input logic cl, input logic fe, input logic pe);
      logic ov, un;
      rx_valid = v; rx_data = d; rd_en = rd; flush = fl; clr = cl; rx_fe = fe; rx_pe = pe;
      @(posedge clk);
      ov = 1'b0;
      un = 1'b0;
      if (fl) begin
         mq.delete();
      end else begin
         if (rd && mq.size() == 0) un = 1'b1;
         if (rd && mq.size() > 0) void'(mq.pop_front());
         if (v) begin
            if (mq.size() < DEPTH) mq.push_back(d);
            else ov = 1'b1;
         end
      end
      m_ovr = (m_ovr & ~cl) | ov;
      m_und = (m_und & ~cl) | un;
      m_fe  = (m_fe & ~cl) | fe;
      m_pe  = (m_pe & ~cl) | pe;
      #1;
      rx_valid = 1'b0; rd_en = 1'b0; flush = 1'b0; clr = 1'b0; rx_fe = 1'b0; rx_pe = 1'b0;
      $display("t=%0t wr=%0b d=%02h rd=%0b fl=%0b clr=%0b fe=%0b pe=%0b -> count=%0d model=%0d",
               $time, v, d, rd, fl, cl, fe, pe, count, mq.size());
   endtask

   task automatic test_reset();
      #2 reset_n = 1'b0;
      #2;
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %0b want 1", empty); end
      checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %0b want 0", full); end
      checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
      checks++; if ({overrun, underflow, frame_err, parity_err} !== 4'b0)
         begin errors++; $display("FAIL reset_flags: got %04b want 0000", {overrun, underflow, frame_err, parity_err}); end
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %0b want 0", irq); end
      @(negedge clk) reset_n = 1'b1;
      mq.delete();
      {m_ovr, m_und, m_fe, m_pe} = 4'b0;
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 5; i++) step(1'b1, 8'(8'hC0 + i), 0, 0, 0, 0, 0);
      step(0, 8'h00, 0, 0, 0, 0, 1'b1);
      checks++; if (count !== 5'd5) begin errors++; $display("FAIL areset_pre_count: got %0d want 5", count); end
      #2 reset_n = 1'b0;
      #1;
      checks++; if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0)
         begin errors++; $display("FAIL areset_async: count=%0d empty=%0b full=%0b want 0/1/0", count, empty, full); end
      checks++; if ({overrun, underflow, frame_err, parity_err, irq} !== 5'b0)
         begin errors++; $display("FAIL areset_flags: got %05b want 00000", {overrun, underflow, frame_err, parity_err, irq}); end
      @(negedge clk) reset_n = 1'b1;
      mq.delete();
      {m_ovr, m_und, m_fe, m_pe} = 4'b0;
   endtask

   task automatic test_fill_drain();
      for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 0, 0, 0, 0, 0);
      checks++; if (full !== 1'b1 || count !== 5'd16)
         begin errors++; $display("FAIL fill_full: full=%0b count=%0d want 1/16", full, count); end
      for (int i = 0; i < 16; i++) begin
         checks++; if (rd_data !== 8'(i) || empty !== 1'b0)
            begin errors++; $display("FAIL drain_data[%0d]: got %02h empty=%0b want %02h", i, rd_data, empty, i); end
         step(0, 8'h00, 1'b1, 0, 0, 0, 0);
      end
      checks++; if (empty !== 1'b1 || count !== 5'd0)
         begin errors++; $display("FAIL drain_empty: empty=%0b count=%0d want 1/0", empty, count); end
   endtask

   task automatic test_overrun();
      for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h10 + i), 0, 0, 0, 0, 0);
      step(1'b1, 8'hAA, 0, 0, 0, 0, 0);
      checks++; if (overrun !== 1'b1 || count !== 5'd16)
         begin errors++; $display("FAIL overrun_flag: overrun=%0b count=%0d want 1/16", overrun, count); end
      for (int i = 0; i < 16; i++) begin
         checks++; if (rd_data !== 8'(8'h10 + i))
            begin errors++; $display("FAIL overrun_data[%0d]: got %02h want %02h", i, rd_data, 8'(8'h10 + i)); end
         step(0, 8'h00, 1'b1, 0, 0, 0, 0);
      end
   endtask

   task automatic test_simultaneous();
      step(0, 8'h00, 0, 0, 1'b1, 0, 0);
      for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h20 + i), 0, 0, 0, 0, 0);
      step(1'b1, 8'h55, 1'b1, 0, 0, 0, 0);
      checks++; if (count !== 5'd16 || overrun !== 1'b0)
         begin errors++; $display("FAIL full_wr_pop: count=%0d overrun=%0b want 16/0", count, overrun); end
      for (int i = 0; i < 16; i++) begin
         checks++; if (rd_data !== mq[0])
            begin errors++; $display("FAIL full_wr_pop_data[%0d]: got %02h want %02h", i, rd_data, mq[0]); end
         if (i == 15) begin
            checks++; if (rd_data !== 8'h55)
               begin errors++; $display("FAIL full_wr_pop_last: got %02h want 55", rd_data); end
         end
         step(0, 8'h00, 1'b1, 0, 0, 0, 0);
      end
      step(1'b1, 8'h33, 1'b1, 0, 0, 0, 0);
      checks++; if (count !== 5'd1 || underflow !== 1'b1 || rd_data !== 8'h33)
         begin errors++; $display("FAIL empty_wr_pop: count=%0d underflow=%0b data=%02h want 1/1/33", count, underflow, rd_data); end
      step(0, 8'h00, 1'b1, 0, 0, 0, 0);
   endtask

   task automatic test_flush_status();
      step(0, 8'h00, 0, 0, 1'b1, 0, 0);
      for (int i = 0; i < 7; i++) step(1'b1, 8'(8'h70 + i), 0, 0, 0, 0, 0);
      checks++; if (count !== 5'd7) begin errors++; $display("FAIL flush_pre: count=%0d want 7", count); end
      step(1'b1, 8'h99, 0, 1'b1, 0, 0, 0);
      checks++; if (count !== 5'd0 || empty !== 1'b1)
         begin errors++; $display("FAIL flush: count=%0d empty=%0b want 0/1", count, empty); end
      step(0, 8'h00, 0, 0, 0, 0, 1'b1);
      checks++; if (parity_err !== 1'b1) begin errors++; $display("FAIL parity_set: got %0b want 1", parity_err); end
      step(0, 8'h00, 0, 0, 1'b1, 0, 0);
      checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL parity_clr: got %0b want 0", parity_err); end
      step(0, 8'h00, 0, 0, 1'b1, 1'b1, 0);
      checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL frame_clr_race: got %0b want 1", frame_err); end
      step(0, 8'h00, 0, 0, 1'b1, 0, 0);
      checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL frame_clr: got %0b want 0", frame_err); end
   endtask

   task automatic test_threshold();
      step(0, 8'h00, 0, 1'b1, 1'b1, 0, 0);
      for (int i = 0; i < 7; i++) step(1'b1, 8'(8'h40 + i), 0, 0, 0, 0, 0);
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_7: got %0b want 0", irq); end
      step(1'b1, 8'h47, 0, 0, 0, 0, 0);
      checks++; if (irq !== exp_irq()) begin errors++; $display("FAIL irq_8: got %0b want %0b", irq, exp_irq()); end
      step(0, 8'h00, 1'b1, 0, 0, 0, 0);
      checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_pop: got %0b want 0", irq); end
      step(0, 8'h00, 0, 1'b1, 0, 0, 0);
   endtask

   task automatic test_random();
      logic v, rd, fl, cl, fe, pe;
      int   wr_pct;
      for (int n = 0; n < 400; n++) begin
         wr_pct = ((n / 50) % 2 == 0) ? 80 : 25;
         v  = ($urandom_range(0, 99) < wr_pct);
         rd = ($urandom_range(0, 99) < 100 - wr_pct);
         fl = ($urandom_range(0, 59) == 0);
         cl = ($urandom_range(0, 19) == 0);
         fe = ~v & ($urandom_range(0, 29) == 0);
         pe = ~v & ($urandom_range(0, 29) == 0);
         if (fl) begin v = 1'b0; rd = 1'b0; end
         step(v, 8'($urandom), rd, fl, cl, fe, pe);
         checks++; if (count !== 5'(mq.size()) || empty !== (mq.size() == 0) || full !== (mq.size() == DEPTH))
            begin errors++; $display("FAIL rand_level[%0d]: count=%0d empty=%0b full=%0b want count=%0d", n, count, empty, full, mq.size()); end
         checks++; if ({overrun, underflow, frame_err, parity_err} !== exp_flags())
            begin errors++; $display("FAIL rand_flags[%0d]: got %04b want %04b", n, {overrun, underflow, frame_err, parity_err}, exp_flags()); end
         checks++; if (irq !== exp_irq())
            begin errors++; $display("FAIL rand_irq[%0d]: got %0b want %0b", n, irq, exp_irq()); end
         if (mq.size() > 0) begin
            checks++; if (rd_data !== mq[0])
               begin errors++; $display("FAIL rand_data[%0d]: got %02h want %02h", n, rd_data, mq[0]); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_async_reset();
      test_fill_drain();
      test_overrun();
      test_simultaneous();
      test_flush_status();
      test_threshold();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
